// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage controller.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_LANE0 = 4'b0001;
    localparam logic [3:0] BE_LANE1 = 4'b0010;
    localparam logic [3:0] BE_LANE2 = 4'b0100;
    localparam logic [3:0] BE_LANE3 = 4'b1000;

    // Wide enough for any legal TIMEOUT (1..255).
    localparam int CNT_W = 8;

    // One-hot byte enable for a lane, lane 0 = bits 7:0.
    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        logic [3:0] be;
        unique case (lane)
            2'd0:    be = BE_LANE0;
            2'd1:    be = BE_LANE1;
            2'd2:    be = BE_LANE2;
            default: be = BE_LANE3;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteEn;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_byteEn,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_byteEn,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_formatter.sv
// Byte-lane formatting: store replication / byte enables, load lane select.
module load_store_formatter
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_st_data,
    input  logic [1:0]  i_st_lane,
    input  logic        i_st_byte,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_byteEn,
    input  logic [31:0] i_ld_rdata,
    input  logic [1:0]  i_ld_lane,
    input  logic        i_ld_byte,
    output logic [31:0] o_ld_data
);
    logic [7:0] w_ld_byte;

    // Store side: byte stores replicate to every lane, memory picks via byteEn.
    always_comb begin
        o_wdata  = i_st_byte ? {4{i_st_data[7:0]}} : i_st_data;
        o_byteEn = i_st_byte ? lane_be(i_st_lane) : BE_WORD;
    end

    // Load side: word loads ignore the low address bits, byte loads zero-extend.
    always_comb begin
        w_ld_byte = i_ld_rdata[{i_ld_lane, 3'b000} +: 8];
        o_ld_data = i_ld_byte ? {24'h0, w_ld_byte} : i_ld_rdata;
    end
endmodule

// File: rtl/mem_stage_controller.sv
// Memory-stage controller: runs req/ack transactions with data memory,
// stalls upstream while outstanding, and builds the MEM/WB payload.
module mem_stage_controller
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        aluResult,
    input  logic [31:0]        storeData,
    input  logic               memRead,
    input  logic               memWrite,
    input  logic               byteAccess,
    input  logic [3:0]         rd_In,
    input  logic [3:0]         CPSRStatus_In,
    input  logic               linkBit_In,
    input  logic               writebackEnable_In,
    mem_stage_if.master        mem,
    output logic [31:0]        dataMemOut,
    output logic [3:0]         rd_Out,
    output logic [3:0]         CPSRStatus_Out,
    output logic               linkBit_Out,
    output logic               writebackEnable_Out,
    output logic               stall,
    output logic               memFault
);
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_req, r_we, r_fault;
    logic [31:0]        r_addr, r_wdata, r_data;
    logic [3:0]         r_be, r_rd, r_cpsr;
    logic               r_link, r_wbe, r_byte, r_load;
    logic [1:0]         r_lane;
    logic               w_memop, w_timeout;
    logic [31:0]        w_st_wdata, w_ld_data;
    logic [3:0]         w_st_be;

    assign w_memop   = memRead | memWrite;
    // Last permitted REQ cycle with no ack; an ack in that cycle still wins.
    assign w_timeout = (r_state == REQ) && !mem.mem_ack &&
                       (r_cnt == CNT_W'(TIMEOUT - 1));

    load_store_formatter u_fmt (
        .i_st_data  (storeData),
        .i_st_lane  (aluResult[1:0]),
        .i_st_byte  (byteAccess),
        .o_wdata    (w_st_wdata),
        .o_byteEn   (w_st_be),
        .i_ld_rdata (mem.mem_rdata),
        .i_ld_lane  (r_lane),
        .i_ld_byte  (r_byte),
        .o_ld_data  (w_ld_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state: acks outside REQ are ignored, RESP always lasts one cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_memop) w_next = REQ;
            REQ:     if (mem.mem_ack || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus and payload registers; inputs are sampled only on the IDLE->REQ edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_req <= 1'b0;  r_we <= 1'b0;  r_fault <= 1'b0;  r_cnt <= '0;
            r_addr <= '0;   r_wdata <= '0; r_be <= '0;       r_data <= '0;
            r_rd <= '0;     r_cpsr <= '0;  r_link <= 1'b0;   r_wbe <= 1'b0;
            r_byte <= 1'b0; r_load <= 1'b0; r_lane <= '0;
        end else begin
            r_fault <= 1'b0;
            unique case (r_state)
                IDLE: if (w_memop) begin
                    r_req   <= 1'b1;
                    r_we    <= memWrite;
                    r_addr  <= {aluResult[31:2], 2'b00};
                    r_wdata <= w_st_wdata;
                    r_be    <= w_st_be;
                    r_rd    <= rd_In;
                    r_cpsr  <= CPSRStatus_In;
                    r_link  <= linkBit_In;
                    r_wbe   <= writebackEnable_In;
                    r_byte  <= byteAccess;
                    r_lane  <= aluResult[1:0];
                    r_load  <= memRead;
                    r_data  <= '0;
                    r_cnt   <= '0;
                end
                REQ: if (mem.mem_ack) begin
                    r_req  <= 1'b0;
                    r_we   <= 1'b0;
                    r_data <= r_load ? w_ld_data : 32'h0;
                end else if (w_timeout) begin
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                    r_data  <= '0;
                    r_wbe   <= 1'b0;
                    r_fault <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req    = r_req;
    assign mem.mem_we     = r_we;
    assign mem.mem_addr   = r_addr;
    assign mem.mem_wdata  = r_wdata;
    assign mem.mem_byteEn = r_be;
    assign memFault       = r_fault;

    // Stall covers the IDLE cycle of a memory op plus every REQ cycle.
    assign stall = reset && ((r_state == REQ) || ((r_state == IDLE) && w_memop));

    // Payload: pass-through in IDLE, latched copy otherwise; writeback only
    // leaves when the MEM/WB register actually captures a completed op.
    always_comb begin
        dataMemOut          = aluResult;
        rd_Out              = rd_In;
        CPSRStatus_Out      = CPSRStatus_In;
        linkBit_Out         = linkBit_In;
        writebackEnable_Out = writebackEnable_In & ~w_memop;
        if (r_state != IDLE) begin
            dataMemOut          = r_data;
            rd_Out              = r_rd;
            CPSRStatus_Out      = r_cpsr;
            linkBit_Out         = r_link;
            writebackEnable_Out = (r_state == RESP) & r_wbe;
        end
        if (!reset) writebackEnable_Out = 1'b0;
    end
endmodule

// File: tb/tb_mem_stage_controller.sv
// Scoreboard bench: driver pushes expected bus requests and payloads,
// a memory responder follows a per-op plan, a monitor pops and compares.
module tb_mem_stage_controller;
    import mem_stage_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] aluResult = '0, storeData = '0;
    logic        memRead = 1'b0, memWrite = 1'b0, byteAccess = 1'b0;
    logic [3:0]  rd_In = '0, CPSRStatus_In = '0;
    logic        linkBit_In = 1'b0, writebackEnable_In = 1'b0;
    logic [31:0] dataMemOut;
    logic [3:0]  rd_Out, CPSRStatus_Out;
    logic        linkBit_Out, writebackEnable_Out, stall, memFault;

    mem_stage_if mem();

    mem_stage_controller #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .aluResult(aluResult), .storeData(storeData),
        .memRead(memRead), .memWrite(memWrite), .byteAccess(byteAccess),
        .rd_In(rd_In), .CPSRStatus_In(CPSRStatus_In), .linkBit_In(linkBit_In),
        .writebackEnable_In(writebackEnable_In), .mem(mem),
        .dataMemOut(dataMemOut), .rd_Out(rd_Out), .CPSRStatus_Out(CPSRStatus_Out),
        .linkBit_Out(linkBit_Out), .writebackEnable_Out(writebackEnable_Out),
        .stall(stall), .memFault(memFault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rd, cpsr;
        logic        link, wbe, fault;
        int          stalls;
    } exp_t;
    typedef struct {
        logic [31:0] addr, wdata;
        logic        we;
        logic [3:0]  be;
        logic        is_store;
    } req_t;
    typedef struct {
        int          lat;
        logic [31:0] rdata;
    } plan_t;

    exp_t  exp_q[$];
    req_t  req_q[$];
    plan_t plan_q[$];

    int          checks = 0, fails = 0;
    bit          mon_en = 1'b0, resp_en = 1'b1;
    logic        force_ack = 1'b0;
    logic [31:0] force_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: acks in the planned REQ cycle, sprinkles stray acks elsewhere.
    initial begin
        int    cnt;
        bit    prev;
        plan_t p;
        cnt = 0; prev = 1'b0; p.lat = 255; p.rdata = '0;
        mem.mem_ack = 1'b0; mem.mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem.mem_ack = 1'b0;
            if (!resp_en) begin
                mem.mem_ack   = force_ack;
                mem.mem_rdata = force_rdata;
            end else if (mem.mem_req) begin
                if (!prev) begin
                    cnt = 0;
                    if (plan_q.size() > 0) p = plan_q.pop_front();
                    else p.lat = 255;
                end
                cnt++;
                if (cnt == p.lat) begin
                    mem.mem_ack   = 1'b1;
                    mem.mem_rdata = p.rdata;
                end else begin
                    mem.mem_rdata = $urandom;
                end
            end else if ($urandom_range(3) == 0) begin
                mem.mem_ack   = 1'b1;
                mem.mem_rdata = $urandom;
            end
            prev = mem.mem_req;
        end
    end

    // Monitor: check each new request, and the payload whenever stall is low.
    initial begin
        int   stalls;
        bit   prev;
        exp_t e;
        req_t q;
        stalls = 0; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && mon_en) begin
                if (mem.mem_req && !prev) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        q = req_q.pop_front();
                        chk("mem_addr", mem.mem_addr, q.addr);
                        chk("mem_we", {31'd0, mem.mem_we}, {31'd0, q.we});
                        if (q.is_store) begin
                            chk("mem_wdata", mem.mem_wdata, q.wdata);
                            chk("mem_byteEn", {28'd0, mem.mem_byteEn}, {28'd0, q.be});
                        end
                    end
                end
                if (stall) begin
                    stalls++;
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_payload", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dataMemOut", dataMemOut, e.data);
                    chk("rd_Out", {28'd0, rd_Out}, {28'd0, e.rd});
                    chk("CPSRStatus_Out", {28'd0, CPSRStatus_Out}, {28'd0, e.cpsr});
                    chk("linkBit_Out", {31'd0, linkBit_Out}, {31'd0, e.link});
                    chk("writebackEnable_Out", {31'd0, writebackEnable_Out}, {31'd0, e.wbe});
                    chk("memFault", {31'd0, memFault}, {31'd0, e.fault});
                    chk("stall_cycles", stalls, e.stalls);
                    stalls = 0;
                end
            end else begin
                stalls = 0;
            end
            prev = mem.mem_req;
        end
    end

    // Issue one instruction from EX/MEM (called just after a rising edge) and
    // hold it until the controller releases the stall.
    task automatic run_op(input bit rd_op, input bit wr_op, input bit byt,
                          input logic [31:0] alu, input logic [31:0] sd,
                          input logic [3:0] rdv, input logic [3:0] cpsr,
                          input logic link, input logic wbe,
                          input int lat, input logic [31:0] rdata);
        exp_t  e;
        req_t  q;
        plan_t p;
        int    lane, guard;
        bit    st;
        lane = int'(alu[1:0]);
        e.rd = rdv; e.cpsr = cpsr; e.link = link; e.wbe = wbe;
        e.fault = 1'b0; e.stalls = 0; e.data = alu;
        if (rd_op || wr_op) begin
            q.addr     = alu & 32'hFFFF_FFFC;
            q.we       = wr_op;
            q.wdata    = byt ? (sd & 32'hFF) * 32'h0101_0101 : sd;
            q.be       = byt ? 4'(1 << lane) : 4'hF;
            q.is_store = wr_op;
            req_q.push_back(q);
            p.lat = lat; p.rdata = rdata;
            plan_q.push_back(p);
            if (lat > TO) begin
                e.data = '0; e.wbe = 1'b0; e.fault = 1'b1; e.stalls = 1 + TO;
            end else begin
                e.stalls = 1 + lat;
                if (wr_op)    e.data = '0;
                else if (byt) e.data = (rdata >> (8 * lane)) & 32'hFF;
                else          e.data = rdata;
            end
        end
        exp_q.push_back(e);
        memRead = rd_op; memWrite = wr_op; byteAccess = byt;
        aluResult = alu; storeData = sd; rd_In = rdv; CPSRStatus_In = cpsr;
        linkBit_In = link; writebackEnable_In = wbe;
        mon_en = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            st = stall;
            guard++;
            @(posedge clk);
            #1;
        end while (st && guard < 100);
        if (guard >= 100) chk("op_stall_bound", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset: a load is presented, but nothing may start or stall.
        memRead = 1'b1; aluResult = 32'h104; writebackEnable_In = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem.mem_we}, 32'd0);
        chk("rst_mem_addr", mem.mem_addr, 32'd0);
        chk("rst_mem_wdata", mem.mem_wdata, 32'd0);
        chk("rst_mem_byteEn", {28'd0, mem.mem_byteEn}, 32'd0);
        chk("rst_memFault", {31'd0, memFault}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wbe_out", {31'd0, writebackEnable_Out}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; memRead = 1'b0;

        // Directed cases.
        run_op(0, 0, 0, 32'h0000_0042, 32'h0, 4'd3, 4'h5, 1'b0, 1'b1, 0, 32'h0);
        run_op(1, 0, 0, 32'h0000_0100, 32'h0, 4'd1, 4'h2, 1'b0, 1'b1, 1, 32'hDEAD_BEEF);
        run_op(1, 0, 1, 32'h0000_0103, 32'h0, 4'd2, 4'h0, 1'b1, 1'b1, 2, 32'h1122_3344);
        run_op(0, 1, 1, 32'h0000_0201, 32'hAB, 4'd4, 4'h8, 1'b0, 1'b0, 1, 32'h0);
        run_op(1, 0, 0, 32'h0000_0300, 32'h0, 4'd5, 4'hF, 1'b0, 1'b1, 255, 32'h0);
        run_op(1, 0, 0, 32'h0000_0304, 32'h0, 4'd6, 4'h1, 1'b1, 1'b1, TO, 32'h1234_5678);
        run_op(0, 1, 0, 32'h0000_0402, 32'hCAFE_F00D, 4'd7, 4'h3, 1'b0, 1'b0, 3, 32'h0);

        // Random mix of ALU ops, loads and stores with varied ack latency.
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(2);
            run_op(kind == 1, kind == 2, 1'($urandom_range(1)), $urandom, $urandom,
                   4'($urandom), 4'($urandom), 1'($urandom_range(1)),
                   1'($urandom_range(1)), $urandom_range(1, TO + 2), $urandom);
        end
        mon_en = 1'b0;

        // Reset in the second REQ cycle, then a late ack that must be ignored.
        resp_en = 1'b0;
        memRead = 1'b1; memWrite = 1'b0; byteAccess = 1'b0; aluResult = 32'h500;
        writebackEnable_In = 1'b1;
        @(posedge clk); #1;     // now REQ cycle 1
        @(posedge clk); #1;     // now REQ cycle 2
        reset = 1'b0;
        @(negedge clk);
        chk("rstreq_stall_low", {31'd0, stall}, 32'd0);
        chk("rstreq_wbe_low", {31'd0, writebackEnable_Out}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        memRead = 1'b0; aluResult = 32'h55; rd_In = 4'd9;
        force_ack = 1'b1; force_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("rstreq_mem_req", {31'd0, mem.mem_req}, 32'd0);
        chk("rstreq_state", {30'd0, dut.r_state}, 32'd0);
        chk("rstreq_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_mem_req", {31'd0, mem.mem_req}, 32'd0);
        chk("late_ack_state", {30'd0, dut.r_state}, 32'd0);
        chk("late_ack_fault", {31'd0, memFault}, 32'd0);
        chk("late_ack_data", dataMemOut, 32'h55);
        chk("late_ack_stall", {31'd0, stall}, 32'd0);

        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("req_q_drained", req_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
